// File: rtl/dummy_dac_pkg.sv
// Shared definitions for the dummy DAC playback slot: register map,
// control bit positions, FSM state encoding and the default check pattern.
package dummy_dac_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_ERR      = 2'd1;
    localparam logic [1:0] REG_UNDERRUN = 2'd2;
    localparam logic [1:0] REG_GOOD     = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    localparam logic [31:0] DEFAULT_EXPECTED = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        COLLECT,
        DONE
    } state_t;

    // Status counters stick at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/dummy_dac_if.sv
// Read side of the slot FIFO as seen by the dummy DAC.
// Handshake: fifo_read is a one-clk pop strobe with no backpressure; the popped
// byte appears on fifo_data on the clk after the strobe. The consumer only pops
// when the pointer difference shows enough bytes, so no empty flag exists.
interface dummy_dac_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  fifo_clk;
    logic                  fifo_read;
    logic [7:0]            fifo_data;
    logic [ADDR_WIDTH-1:0] fifo_addr_in;
    logic [ADDR_WIDTH-1:0] fifo_addr_out;

    modport master (
        output fifo_clk,
        output fifo_read,
        input  fifo_data,
        input  fifo_addr_in,
        input  fifo_addr_out
    );

    modport slave (
        input  fifo_clk,
        input  fifo_read,
        output fifo_data,
        output fifo_addr_in,
        output fifo_addr_out
    );
endinterface

// File: rtl/dummy_dac_serializer.sv
// Pseudo-DAC shifter: on every sample tick it takes a snapshot of the holding
// word and plays it out MSB first, one bit per BIT_DIV clks. Zeros follow once
// all 32 bits are out, so the line idles low until the next tick.
module dummy_dac_serializer #(
    parameter int BIT_DIV = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [31:0] word,
    output logic        dac_data,
    output logic        dac_frame
);
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    // Bit 31 goes straight to dac_data at load; only the remaining 31 are held.
    logic [30:0]      shift_reg;
    logic [DIV_W-1:0] div_cnt;

    // Tick reload, then a BIT_DIV-paced shift with frame marking the first bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            div_cnt   <= '0;
            dac_data  <= 1'b0;
            dac_frame <= 1'b0;
        end else if (tick) begin
            shift_reg <= word[30:0];
            div_cnt   <= '0;
            dac_data  <= word[31];
            dac_frame <= 1'b1;
        end else if (div_cnt == DIV_W'(BIT_DIV - 1)) begin
            shift_reg <= {shift_reg[29:0], 1'b0};
            div_cnt   <= '0;
            dac_data  <= shift_reg[30];
            dac_frame <= 1'b0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/dummy_dac.sv
// dummy_dac: stands in for a missing DAC on a playback slot. Each sample tick
// it pops one 32-bit word (4 bytes, LSB first) from the slot FIFO, serializes
// the previous word on dac_data and keeps status counters on the config port.
// Define DUMMY_DAC_CHECK_EN to compare each word against EXPECTED; without it
// reg1 reads 0 and reg3 counts every completed word.
module dummy_dac
    import dummy_dac_pkg::*;
#(
    parameter int          CLK_DIV    = 256,
    parameter int          BIT_DIV    = 8,
`ifdef DUMMY_DAC_CHECK_EN
    parameter logic [31:0] EXPECTED   = DEFAULT_EXPECTED,
`endif
    parameter int          ADDR_WIDTH = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        config_write,
    input  logic        config_read,
    input  logic [1:0]  config_addr,
    inout  wire  [7:0]  config_data,
    dummy_dac_if.master fifo,
    input  logic        direction,
    output logic        dac_data,
    output logic        dac_frame,
    output state_t      state_dbg
);
    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [TICK_W-1:0]     tick_cnt;
    logic                  tick;
    logic [ADDR_WIDTH-1:0] occupancy;
    state_t                state, state_next;
    logic [1:0]            pop_cnt;
    logic                  rd_d;
    logic [1:0]            rd_idx;
    logic [31:0]           holding;
    logic                  underrun;
    logic                  enable;
    logic                  ctrl_write, clear_req, word_done;
    logic [7:0]            err_cnt, underrun_cnt, good_cnt;
    logic [7:0]            read_data;

    assign fifo.fifo_clk = clk;
    assign tick          = (tick_cnt == TICK_W'(CLK_DIV - 1));
    assign occupancy     = fifo.fifo_addr_in - fifo.fifo_addr_out;
    assign state_dbg     = state;
    assign word_done     = (state == DONE);
    assign ctrl_write    = config_write && (config_addr == REG_CTRL);
    assign clear_req     = ctrl_write && config_data[CTRL_CLEAR_BIT];

    // Free-running sample tick divider.
    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + TICK_W'(1);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state; only IDLE looks at enable/direction, so a started word always finishes.
    always_comb begin
        state_next = state;
        underrun   = 1'b0;
        case (state)
            IDLE: begin
                if (tick && enable && !direction) begin
                    if (occupancy >= ADDR_WIDTH'(4)) state_next = POP;
                    else                             underrun   = 1'b1;
                end
            end
            POP:     if (pop_cnt == 2'd3) state_next = COLLECT;
            COLLECT: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign fifo.fifo_read = (state == POP);

    // Pop index plus a one-clk delayed copy that steers the returning byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_cnt <= '0;
            rd_d    <= 1'b0;
            rd_idx  <= '0;
        end else begin
            pop_cnt <= (state == POP) ? pop_cnt + 2'd1 : 2'd0;
            rd_d    <= fifo.fifo_read;
            rd_idx  <= pop_cnt;
        end
    end

    // Holding word: assembled LSB first, zeroed on underrun.
    always_ff @(posedge clk) begin
        if (reset)         holding <= '0;
        else if (underrun) holding <= '0;
        else if (rd_d)     holding[8*rd_idx +: 8] <= fifo.fifo_data;
    end

    // Enable bit; the clear bit is a strobe and is never stored.
    always_ff @(posedge clk) begin
        if (reset)           enable <= 1'b0;
        else if (ctrl_write) enable <= config_data[CTRL_ENABLE_BIT];
    end

    // Saturating status counters; a clear in the same clk beats any increment.
    always_ff @(posedge clk) begin
        if (reset || clear_req) begin
            underrun_cnt <= '0;
            good_cnt     <= '0;
        end else begin
            if (underrun) underrun_cnt <= sat_inc(underrun_cnt);
`ifdef DUMMY_DAC_CHECK_EN
            if (word_done && holding == EXPECTED) good_cnt <= sat_inc(good_cnt);
`else
            if (word_done) good_cnt <= sat_inc(good_cnt);
`endif
        end
    end

`ifdef DUMMY_DAC_CHECK_EN
    // Mismatch counter, only present with the comparator.
    always_ff @(posedge clk) begin
        if (reset || clear_req) err_cnt <= '0;
        else if (word_done && holding != EXPECTED) err_cnt <= sat_inc(err_cnt);
    end
`else
    assign err_cnt = 8'd0;
`endif

    // Registered read mux: data reflects the address seen on the previous clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data <= '0;
        end else begin
            case (config_addr)
                REG_CTRL:     read_data <= {7'd0, enable};
                REG_ERR:      read_data <= err_cnt;
                REG_UNDERRUN: read_data <= underrun_cnt;
                default:      read_data <= good_cnt;
            endcase
        end
    end

    assign config_data = config_read ? read_data : 8'hzz;

    dummy_dac_serializer #(
        .BIT_DIV (BIT_DIV)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .word      (holding),
        .dac_data  (dac_data),
        .dac_frame (dac_frame)
    );
endmodule

// File: tb/tb_dummy_dac.sv
// Bench for dummy_dac: bench-owned FIFO, a word-level reference model updated
// at each sample tick, and a monitor that deserializes dac_data and pops the
// expected word from exp_q. Runs with a shortened sample period.
`timescale 1ns/1ps
module tb_dummy_dac;
    import dummy_dac_pkg::*;

    localparam int          CLK_DIV = 128;
    localparam int          BIT_DIV = 4;
    localparam int          AW      = 11;
    localparam int          WORD_CY = 32 * BIT_DIV;
    localparam logic [31:0] PATTERN = 32'hDEADBEEF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       config_write = 1'b0;
    logic       config_read  = 1'b0;
    logic [1:0] config_addr  = 2'd0;
    logic       drive_en     = 1'b0;
    logic [7:0] drive_data   = 8'd0;
    wire  [7:0] config_data;
    logic       direction = 1'b0;
    logic       dac_data, dac_frame;
    state_t     state_dbg;

    assign config_data = drive_en ? drive_data : 8'hzz;

    dummy_dac_if #(.ADDR_WIDTH(AW)) fifo_bus ();

    dummy_dac #(
        .CLK_DIV    (CLK_DIV),
        .BIT_DIV    (BIT_DIV),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .config_write (config_write),
        .config_read  (config_read),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .fifo         (fifo_bus),
        .direction    (direction),
        .dac_data     (dac_data),
        .dac_frame    (dac_frame),
        .state_dbg    (state_dbg)
    );

    // ---------------- bench FIFO ----------------
    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr = '0;
    logic [AW-1:0] rd_ptr = '0;
    logic          set_ptr_req = 1'b0;
    logic [AW-1:0] set_ptr_val = '0;

    assign fifo_bus.fifo_addr_in  = wr_ptr;
    assign fifo_bus.fifo_addr_out = rd_ptr;

    always @(posedge clk) begin
        if (set_ptr_req) begin
            rd_ptr <= set_ptr_val;
        end else if (fifo_bus.fifo_read) begin
            fifo_bus.fifo_data <= mem[rd_ptr];
            rd_ptr             <= rd_ptr + 1'b1;
        end
    end

    int tb_cyc;
    always @(posedge clk) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    // ---------------- scoreboard / model state ----------------
    logic [31:0] exp_q[$];
    logic [7:0]  model_fifo[$];
    logic [31:0] model_hold = '0;
    logic        model_en   = 1'b0;
    int          model_err  = 0;
    int          model_und  = 0;
    int          model_good = 0;
    int          chk_cnt    = 0;
    int          pass_cnt   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_phase(input int p);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((tb_cyc % CLK_DIV) != p && n < 4 * CLK_DIV);
        if (n >= 4 * CLK_DIV) check("wait_phase_timeout", 32'(n), 32'(p));
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 1'b1;
        model_fifo.push_back(b);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) push_byte(w[8*k +: 8]);
    endtask

    // Empties the FIFO and points both pointers at ptr.
    task automatic flush_fifo(input logic [AW-1:0] ptr);
        set_ptr_val = ptr;
        set_ptr_req = 1'b1;
        wr_ptr      = ptr;
        model_fifo.delete();
        @(negedge clk);
        set_ptr_req = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        config_write = 1'b1;
        config_addr  = a;
        drive_en     = 1'b1;
        drive_data   = d;
        if (a == REG_CTRL) begin
            model_en = d[0];
            if (d[1]) begin
                model_err  = 0;
                model_und  = 0;
                model_good = 0;
            end
        end
        @(negedge clk);
        config_write = 1'b0;
        drive_en     = 1'b0;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [7:0] exp, input string name);
        config_read = 1'b1;
        config_addr = a;
        @(negedge clk);
        check(name, {24'd0, config_data}, {24'd0, exp});
        config_read = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [AW-1:0] occ;
        read_check(REG_CTRL,     {7'd0, model_en},  {tag, "_reg0"});
        read_check(REG_ERR,      8'(model_err),     {tag, "_reg1_err"});
        read_check(REG_UNDERRUN, 8'(model_und),     {tag, "_reg2_underrun"});
        read_check(REG_GOOD,     8'(model_good),    {tag, "_reg3_good"});
        occ = wr_ptr - rd_ptr;
        check({tag, "_occupancy"}, 32'(occ), 32'(model_fifo.size()));
    endtask

    // Reference behaviour of one sample tick, called on the tick cycle.
    task automatic model_tick(output logic started);
        logic [31:0] w;
        started = 1'b0;
        exp_q.push_back(model_hold);
        if (model_en && !direction) begin
            if (model_fifo.size() >= 4) begin
                started = 1'b1;
                w = '0;
                for (int k = 0; k < 4; k++) w = w | ({24'd0, model_fifo.pop_front()} << (8 * k));
`ifdef DUMMY_DAC_CHECK_EN
                if (w == PATTERN) begin if (model_good < 255) model_good++; end
                else              begin if (model_err < 255)  model_err++;  end
`else
                if (model_good < 255) model_good++;
`endif
                model_hold = w;
            end else begin
                if (model_und < 255) model_und++;
                model_hold = '0;
            end
        end
    endtask

    // One sample period: tick, count pops that follow, then check status.
    task automatic run_period(input string tag);
        logic started;
        int   pops;
        wait_phase(CLK_DIV - 1);
        model_tick(started);
        pops = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (fifo_bus.fifo_read) pops++;
        end
        check({tag, "_pops"}, 32'(pops), started ? 32'd4 : 32'd0);
        wait_phase(20);
        check_status(tag);
    endtask

    // ---------------- serial monitor ----------------
    logic [31:0] mon_got;
    int          mon_frame;
    logic        mon_abort;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && dac_frame) begin
                mon_got   = '0;
                mon_frame = 0;
                mon_abort = 1'b0;
                for (int k = 0; k < WORD_CY; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) mon_abort = 1'b1;
                    if (dac_frame) mon_frame++;
                    if ((k % BIT_DIV) == BIT_DIV / 2) mon_got = {mon_got[30:0], dac_data};
                end
                if (!mon_abort) begin
                    check("frame_len", 32'(mon_frame), 32'(BIT_DIV));
                    if (exp_q.size() == 0) check("serial_unexpected_word", mon_got, 32'hFFFF_FFFF);
                    else                   check("serial_word", mon_got, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, checks so far %0d", chk_cnt);
        chk_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic       started;
        int         n;
        logic       en_r;

        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_fifo_read", {31'd0, fifo_bus.fifo_read}, 32'd0);
        check("rst_dac_data",  {31'd0, dac_data},  32'd0);
        check("rst_dac_frame", {31'd0, dac_frame}, 32'd0);
        check("rst_state",     {30'd0, state_dbg}, {30'd0, IDLE});
        rst = 1'b0;
        check_status("reset");

        // Happy path: EF BE AD DE gives 0xDEADBEEF.
        direction = 1'b0;
        write_reg(REG_CTRL, 8'h01);
        push_word(PATTERN);
        run_period("happy");

        // Underrun with 3 bytes, then top up so a word completes.
        for (int k = 0; k < 3; k++) push_byte(8'($urandom_range(0, 255)));
        run_period("underrun");
        push_byte(8'($urandom_range(0, 255)));
        run_period("topup");

        // All-zero word exercises the checker.
        push_word(32'h0000_0000);
        run_period("zeros");

        // Pointer wrap: write 0x7FE..0x001, write pointer ends at 0x002.
        flush_fifo(11'h7FE);
        push_word(PATTERN);
        check("wrap_addr_in", {21'd0, wr_ptr}, 32'h002);
        run_period("wrap");

        // Randomized periods.
        for (int p = 0; p < 10; p++) begin
            if ($urandom_range(0, 2) == 0) begin
                push_word(PATTERN);
            end else begin
                n = $urandom_range(0, 6);
                for (int k = 0; k < n; k++) push_byte(8'($urandom_range(0, 255)));
            end
            direction = ($urandom_range(0, 4) == 0);
            en_r      = ($urandom_range(0, 5) != 0);
            write_reg(REG_CTRL, {7'd0, en_r});
            run_period("random");
        end

        // Reset right after the second pop.
        direction = 1'b0;
        write_reg(REG_CTRL, 8'h01);
        push_word(32'($urandom));
        wait_phase(CLK_DIV - 1);
        model_tick(started);
        check("rstmid_started", {31'd0, started}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_fifo_read", {31'd0, fifo_bus.fifo_read}, 32'd0);
        check("rstmid_state",     {30'd0, state_dbg}, {30'd0, IDLE});
        exp_q.delete();
        model_hold = '0;
        model_en   = 1'b0;
        model_err  = 0;
        model_und  = 0;
        model_good = 0;
        flush_fifo('0);
        rst = 1'b0;
        check_status("after_reset");
        write_reg(REG_CTRL, 8'h01);
        push_word(PATTERN);
        run_period("post_reset");

        // Clear written in the DONE clk beats the good-word increment.
        push_word(PATTERN);
        wait_phase(CLK_DIV - 1);
        model_tick(started);
        wait_phase(5);
        check("clear_in_done_state", {30'd0, state_dbg}, {30'd0, DONE});
        write_reg(REG_CTRL, 8'h03);
        wait_phase(20);
        check_status("clear");
        read_check(REG_CTRL, 8'h01, "clear_reg0_readback");

        // Saturation of the underrun counter.
        for (int t = 0; t < 270; t++) begin
            wait_phase(CLK_DIV - 1);
            model_tick(started);
        end
        wait_phase(20);
        check_status("saturate");
        read_check(REG_UNDERRUN, 8'hFF, "underrun_saturated");

        // Direction=1: no pops, counters frozen.
        push_word(PATTERN);
        direction = 1'b1;
        run_period("dir1_a");
        run_period("dir1_b");
        direction = 1'b0;
        run_period("dir0");

        wait_phase(CLK_DIV - 1);
        model_tick(started);
        wait_phase(CLK_DIV - 10);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/dummy_dac.md
Name: dummy_dac

Overview:
- Playback-direction counterpart of the dummy ADC slot module: stands in for a nonexistent DAC.
- Drains 32-bit sample words from the slot FIFO as 4 bytes, LSB first, one word per sample tick.
- Serializes each word MSB first on a pseudo-DAC pin and optionally checks it against a known pattern.
- Status counters are exposed through the standard 4-register slot config port.

Parameters:
- CLK_DIV, 256: clk cycles per sample tick (100 MHz / 256 ≈ 390.6 kHz).
- BIT_DIV, 8: clk cycles per serial bit; CLK_DIV must be ≥ 32*BIT_DIV.
- EXPECTED, 32'hDEADBEEF: pattern used by the word checker.
- ADDR_WIDTH, 11: FIFO pointer width.

Ports:
- clk  in  1  system clock (100 MHz); FIFO and config run on it.
- reset  in  1  synchronous, active-high reset.
- config_write  in  1  register write strobe.
- config_read  in  1  register read enable; drives config_data.
- config_addr  in  2  register select.
- config_data  inout  8  register data; high-Z when config_read=0.
- fifo_clk  out  1  FIFO read clock; equals clk.
- fifo_read  out  1  FIFO pop strobe.
- fifo_data  in  8  FIFO read data, valid one clk after fifo_read.
- fifo_addr_in  in  ADDR_WIDTH  FIFO write pointer.
- fifo_addr_out  in  ADDR_WIDTH  FIFO read pointer.
- direction  in  1  slot direction; 0 = playback. Module is active only when 0.
- dac_data  out  1  serial sample bit.
- dac_frame  out  1  high for the first bit period of each word.

Behaviour:
- Reset values:
  - fifo_read=0, dac_data=0, dac_frame=0.
  - All counters, the holding word, the shift register and reg0 = 0.
  - State = IDLE.
- Register map:
  - reg0: bit0 = enable. bit1 = clear counters, write-only, self-clearing, reads 0.
  - reg1: error count. reg2: underrun count. reg3: good-word count.
  - reg1–reg3 are read-only and saturate at 255.
  - Reads are registered: config_data shows the value of config_addr sampled on the previous clk.
- Occupancy: (fifo_addr_in - fifo_addr_out) mod 2^ADDR_WIDTH. Equal pointers = empty.
- Tick: tick_counter counts 0..CLK_DIV-1 and wraps. Tick = cycle where the counter equals CLK_DIV-1.
- FSM states: IDLE, POP, COLLECT, DONE.
- IDLE:
  - On tick with enable=1, direction=0 and occupancy ≥ 4, go to POP.
  - On tick with enable=1, direction=0 and occupancy < 4: underrun. Increment reg2, clear the holding word to 0, issue no pops, stay in IDLE.
  - Ticks with enable=0 or direction=1: do nothing.
- POP:
  - fifo_read=1 for exactly 4 consecutive clks.
  - Byte k is captured on the clk after pop k into holding bits [8k+7:8k].
- COLLECT: waits for the 4th byte. Total transaction is 5 clks.
- DONE (1 clk): compare against EXPECTED, update reg1/reg3, then return to IDLE.
- A transaction in progress always completes, even if direction or enable changes mid-way.
- Serializer, independent of the FSM:
  - On each tick, the shift register loads the holding word as it stands at that tick (one-sample latency).
  - Shifts MSB first; one bit per BIT_DIV clks; dac_data is registered.
  - dac_frame=1 during bit 31.
  - Loads regardless of enable; zeros shift out when idle or underrun.
- Counter conflicts:
  - Clear and increment in the same clk: clear wins.
  - Counters hold at 255 once saturated.
- Reset mid-transaction: fifo_read drops next clk; partial bytes are discarded; no counter changes.

Optional Feature:
- Macro DUMMY_DAC_CHECK_EN.
- Defined: the DONE compare is active. Mismatch → reg1 increments. Match → reg3 increments.
- Undefined:
  - No comparator is built. reg1 reads 0.
  - reg3 counts every completed word regardless of content.

Decomposition:
- Package dummy_dac_pkg holds:
  - Register address constants REG_CTRL=0, REG_ERR=1, REG_UNDERRUN=2, REG_GOOD=3.
  - The ctrl bit indices.
  - The FSM state enum.
  - DEFAULT_EXPECTED = 32'hDEADBEEF.
- Sub-module dummy_dac_serializer: tick-load, BIT_DIV-paced 32-bit shifter, dac_frame generation.

Test Plan:
- Happy path: preload FIFO with EF BE AD DE; enable, direction=0.
  - Response: 4 fifo_read pulses after the first tick; reg3=1; reg1=0.
  - On the next tick, dac_data shifts 0xDEADBEEF MSB first at 8 clks/bit, with dac_frame high for the first 8 clks.
- Underrun: FIFO holds 3 bytes at tick.
  - Response: no fifo_read; reg2=1; zeros serialized at the next tick.
- Checker (macro defined): FIFO holds 00 00 00 00.
  - Response: reg1=1, reg3=0.
  - With the macro undefined: reg3=1, reg1 reads 0.
- Pointer wrap: fifo_addr_in=0x002, fifo_addr_out=0x7FE (occupancy 4).
  - Response: transaction starts and 4 pops are issued.
- Reset after the 2nd pop:
  - Response: fifo_read=0 the following clk; state IDLE; all counters 0.
  - Next tick with 4 bytes available: a normal transaction.
- Counter control: write reg0=0x03.
  - Response: counters clear, reg0 reads back 0x01.
  - Drive 300 underruns: reg2 saturates at 0xFF.
  - Set direction=1: no pops and no counter changes.
